// File: rtl/countdown_timer.sv
// ============================================================================
// Module   : countdown_timer
// Brief    : Two-digit BCD countdown driven by edge-detected clk_N ticks, with
//            start/pause/load control. Optional macro:
//            COUNTDOWN_TIMER_AUTORELOAD_EN (reload preset at 00 instead of DONE).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module countdown_timer #(
    parameter logic [7:0] DEFAULT_PRESET = 8'h59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_N,
    input  logic       start,
    input  logic       pause,
    input  logic       load,
    input  logic [7:0] preset_bcd,
    output logic [7:0] count_bcd,
    output logic       running,
    output logic       expired,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_pre;
    logic [7:0] w_next_pre;
    logic [7:0] w_next_count;
    logic [7:0] w_dec;
    logic       w_done_set;
    logic       r_s1;
    logic       r_s2;
    logic       w_tick;
    logic       w_load_ok;

    assign w_tick    = r_s1 & ~r_s2;
    assign w_load_ok = load && (preset_bcd[7:4] <= 4'd9) && (preset_bcd[3:0] <= 4'd9)
                       && (preset_bcd != 8'h00);
    // BCD borrow: ones wrap to 9 and tens drop by one
    assign w_dec     = (count_bcd[3:0] != 4'd0) ? {count_bcd[7:4], count_bcd[3:0] - 4'd1}
                                                : {count_bcd[7:4] - 4'd1, 4'd9};

    always_comb begin
        w_next_state = r_state;
        w_next_count = count_bcd;
        w_next_pre   = r_pre;
        w_done_set   = 1'b0;
        if (w_load_ok) begin
            w_next_state = S_IDLE;
            w_next_count = preset_bcd;
            w_next_pre   = preset_bcd;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!pause && start && (count_bcd != 8'h00))
                        w_next_state = S_RUN;
                end
                S_RUN: begin
                    if (pause) begin
                        w_next_state = S_PAUSE;
                    end else if (w_tick) begin
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
                        if (count_bcd == 8'h00) begin
                            w_next_count = r_pre;
                        end else begin
                            w_next_count = w_dec;
                            w_done_set   = (w_dec == 8'h00);
                        end
`else
                        w_next_count = w_dec;
                        if (w_dec == 8'h00) begin
                            w_done_set   = 1'b1;
                            w_next_state = S_DONE;
                        end
`endif
                    end
                end
                S_PAUSE: begin
                    if (!pause && start)
                        w_next_state = S_RUN;
                end
                S_DONE: begin
                    if (!pause && start) begin
                        w_next_count = r_pre;
                        w_next_state = S_RUN;
                    end
                end
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_state   <= S_IDLE;
            r_pre     <= DEFAULT_PRESET;
            count_bcd <= DEFAULT_PRESET;
            running   <= 1'b0;
            expired   <= 1'b0;
            done      <= 1'b0;
        end else begin
            r_s1      <= clk_N;
            r_s2      <= r_s1;
            r_state   <= w_next_state;
            r_pre     <= w_next_pre;
            count_bcd <= w_next_count;
            running   <= (w_next_state == S_RUN);
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
            expired   <= 1'b0;
`else
            expired   <= (w_next_state == S_DONE);
`endif
            done      <= w_done_set;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_countdown_timer.sv
// ============================================================================
// Module   : tb_countdown_timer
// Brief    : Directed plus randomized bench for countdown_timer against an
//            integer-arithmetic reference model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_countdown_timer;

    localparam logic [7:0] c_DEFAULT = 8'h59;
    localparam int c_M_IDLE = 0, c_M_RUN = 1, c_M_PAUSE = 2, c_M_DONE = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_N = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       load = 1'b0;
    logic [7:0] preset_bcd = 8'h00;
    logic [7:0] count_bcd;
    logic       running;
    logic       expired;
    logic       done;

    countdown_timer #(.DEFAULT_PRESET(c_DEFAULT)) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_N      (clk_N),
        .start      (start),
        .pause      (pause),
        .load       (load),
        .preset_bcd (preset_bcd),
        .count_bcd  (count_bcd),
        .running    (running),
        .expired    (expired),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    // reference model: count held as a plain integer 0..99
    int m_cnt = 59, m_pre = 59, m_mode = c_M_IDLE;
    bit m_done = 0, m_sa = 0, m_sb = 0;
    // clk_N generator
    bit cn_en = 0;
    int cn_per = 8, cn_ph = 0;
    int n_done_dut = 0;

    function automatic logic [7:0] to_bcd(int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        bit tick;
        bit ok;
        if (rst) begin
            m_mode = c_M_IDLE; m_cnt = 59; m_pre = 59;
            m_sa = 0; m_sb = 0; m_done = 0;
            return;
        end
        tick = m_sa && !m_sb;
        m_sb = m_sa;
        m_sa = clk_N;
        m_done = 0;
        ok = load && (preset_bcd[7:4] <= 9) && (preset_bcd[3:0] <= 9) && (preset_bcd != 0);
        if (ok) begin
            m_cnt = preset_bcd[7:4] * 10 + preset_bcd[3:0];
            m_pre = m_cnt;
            m_mode = c_M_IDLE;
        end else if (m_mode == c_M_IDLE) begin
            if (!pause && start && m_cnt != 0) m_mode = c_M_RUN;
        end else if (m_mode == c_M_RUN) begin
            if (pause) m_mode = c_M_PAUSE;
            else if (tick) begin
                if (m_cnt == 0) m_cnt = m_pre;
                else begin
                    m_cnt = m_cnt - 1;
                    if (m_cnt == 0) begin
                        m_done = 1;
`ifndef COUNTDOWN_TIMER_AUTORELOAD_EN
                        m_mode = c_M_DONE;
`endif
                    end
                end
            end
        end else if (m_mode == c_M_PAUSE) begin
            if (!pause && start) m_mode = c_M_RUN;
        end else begin
            if (!pause && start) begin
                m_cnt = m_pre;
                m_mode = c_M_RUN;
            end
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        chk("count_bcd", count_bcd, to_bcd(m_cnt));
        chk("running", {7'd0, running}, {7'd0, m_mode == c_M_RUN});
        chk("expired", {7'd0, expired}, {7'd0, m_mode == c_M_DONE});
        chk("done", {7'd0, done}, {7'd0, m_done});
        if (done === 1'b1) n_done_dut++;
        if (cn_en) begin
            cn_ph = (cn_ph + 1) % cn_per;
            clk_N = (cn_ph < cn_per / 2);
        end else begin
            clk_N = 1'b0;
        end
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_load(logic [7:0] v);
        load = 1'b1; preset_bcd = v; cycle(); load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1; cycle(); start = 1'b0;
    endtask

    task automatic do_pause();
        pause = 1'b1; cycle(); pause = 1'b0;
    endtask

    task automatic run_until_cnt(int target, string tag);
        int k;
        k = 0;
        while (m_cnt != target && k < 300) begin
            cycle();
            k++;
        end
        chk(tag, to_bcd(m_cnt), to_bcd(target));
    endtask

    initial begin
        logic [7:0] held;
        bit hit;
        int r;

        // reset held for two cycles
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        chk("reset_count", count_bcd, 8'h59);
        run(2);

        // countdown 12 -> 00 with borrow at 10 -> 09
        do_load(8'h12);
        chk("load12", count_bcd, 8'h12);
        do_start();
        n_done_dut = 0;
        cn_per = 8; cn_ph = cn_per - 1; cn_en = 1;
        run(12 * 8 + 4);
        cn_en = 0;
        run(3);
        chk("done_once", 8'(n_done_dut), 8'd1);
        chk("expired_after", {7'd0, expired}, 8'd1);
        chk("final_zero", count_bcd, 8'h00);

        // restart from DONE reloads stored preset
        do_start();
        chk("restart_count", count_bcd, 8'h12);
        chk("restart_run", {7'd0, running}, 8'd1);

        // pause at 07: ticks ignored, then resume to 06
        cn_ph = cn_per - 1; cn_en = 1;
        run_until_cnt(7, "reach07");
        do_pause();
        run(5 * 8);
        chk("paused07", count_bcd, 8'h07);
        do_start();
        run_until_cnt(6, "resume06");

        // pause coinciding with a tick: no decrement
        held = count_bcd;
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            if (m_sa && !m_sb) begin
                pause = 1'b1; cycle(); pause = 1'b0;
                hit = 1;
            end else begin
                cycle();
            end
        end
        chk("pause_tick_found", {7'd0, hit}, 8'd1);
        chk("pause_tick_hold", count_bcd, held);
        cn_en = 0;
        run(3);

        // invalid loads are ignored
        held = count_bcd;
        do_load(8'h1A);
        chk("load_1A", count_bcd, held);
        do_load(8'h00);
        chk("load_00", count_bcd, held);

        // load beats start in the same cycle
        load = 1'b1; start = 1'b1; preset_bcd = 8'h33; cycle();
        load = 1'b0; start = 1'b0;
        chk("load_start_idle", {7'd0, running}, 8'd0);

        // reset while running at 33
        do_start();
        chk("run33", count_bcd, 8'h33);
        rst = 1'b1; cycle(); rst = 1'b0;
        chk("midrun_reset", count_bcd, 8'h59);
        chk("midrun_reset_run", {7'd0, running}, 8'd0);
        run(2);

`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
        do_load(8'h03);
        do_start();
        n_done_dut = 0;
        cn_per = 8; cn_ph = cn_per - 1; cn_en = 1;
        run(8 * 8 + 2);
        cn_en = 0;
        run(3);
        chk("auto_done_twice", 8'(n_done_dut), 8'd2);
        chk("auto_count", count_bcd, 8'h03);
`endif

        // randomized control against the reference model
        for (int seg = 0; seg < 3; seg++) begin
            cn_per = $urandom_range(4, 12);
            cn_ph = cn_per - 1;
            cn_en = 1;
            for (int i = 0; i < 400; i++) begin
                r = $urandom_range(0, 99);
                if (r < 2) begin
                    rst = 1'b1;
                end else if (r < 8) begin
                    load = 1'b1;
                    if ($urandom_range(0, 1) == 1)
                        preset_bcd = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
                    else
                        preset_bcd = 8'($urandom);
                end else if (r < 12) begin
                    pause = 1'b1;
                end else if (r < 22 && m_mode != c_M_RUN) begin
                    start = 1'b1;
                end
                cycle();
                rst = 1'b0; load = 1'b0; pause = 1'b0; start = 1'b0;
            end
        end
        cn_en = 0;
        run(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
